mc_pc_ir_datapath: RTL and testbench
====================================

Name: mc_pc_ir_datapath

Overview:
- Architectural and non-architectural register stage of the multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, plus a fetched-instruction counter.
- Sits directly downstream of the multicycle main decoder and consumes its PCWrite, PCWriteCond, IorD, IRWrite and pcsrc outputs.
- Feeds the decoder's opcode input from the IR and supplies the memory address mux.
- Closes the controller/datapath loop: decoder drives on negedge, this block registers on posedge.

Parameters:
- WIDTH, 32, datapath word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (0 = reset).
- pcwrite  in  1  unconditional PC write enable.
- pcwritecond  in  1  conditional (branch) PC write enable.
- iord  in  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  in  1  IR load enable.
- pcsrc  in  2  next-PC select.
- alu_result  in  WIDTH  combinational ALU output.
- alu_zero  in  1  ALU zero flag.
- rd1, rd2  in  WIDTH  register-file read data.
- mem_rdata  in  WIDTH  memory read data.
- pc  out  WIDTH  current PC.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  equals b_reg.
- ir  out  WIDTH  instruction register.
- op  out  6  ir[31:26], to the decoder.
- funct  out  6  ir[5:0], to the ALU decoder.
- mdr, a_reg, b_reg, aluout  out  WIDTH  holding registers.
- pc_en  out  1  PC load strobe this cycle.
- instr_count  out  CNT_WIDTH  instructions fetched since reset.
- pcsrc_err  out  1  sticky flag: pcsrc==2'b11 seen while pc_en=1.

Behaviour:
- Reset (reset=0, asynchronous, mid-cycle included) values:
  - pc=RESET_PC.
  - ir, mdr, a_reg, b_reg, aluout = 0.
  - instr_count=0, pcsrc_err=0.
  - Outputs update immediately on assertion, with no clock edge required.
  - Deassertion is sampled at the next posedge.
- Branch sense:
  - taken = alu_zero XOR (ir[31:26]==6'b000101).
  - beq takes on zero; bne takes on nonzero.
- pc_en = pcwrite | (pcwritecond & taken). Combinational.
- Next PC:
  - pcsrc 00: alu_result.
  - pcsrc 01: aluout (branch target).
  - pcsrc 10: {pc[31:28], ir[25:0], 2'b00}.
  - pcsrc 11: hold pc and set pcsrc_err (if pc_en=1).
- pc updates at posedge when pc_en=1.
- ir <= mem_rdata at posedge when irwrite=1; otherwise it holds.
- instr_count increments at each posedge with irwrite=1. It wraps from all-ones to 0 with no error.
- mdr, a_reg, b_reg and aluout load every posedge, unconditionally, from mem_rdata, rd1, rd2 and alu_result respectively.
- mem_addr = iord ? aluout : pc. Combinational. Latency 0.
- Simultaneous irwrite and pc_en in the same cycle (fetch):
  - IR captures data for the pre-update PC, because mem_addr uses the old pc.
  - PC takes the new value at the same edge.
- Jump target uses the IR contents present before the edge, never the IR value loaded at that same edge.
- pcwrite=1 and pcwritecond=1 together: pc_en=1 regardless of taken.
- X on control inputs during reset is ignored. After reset, control inputs must not be X when clk rises.

Decomposition:
- Shared package mc_defs holds:
  - PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10.
  - OP_BNE=6'b000101, OP_BEQ=6'b000100.
  - Reuse these in the main decoder.
- One natural sub-module: mc_en_reg, a WIDTH-parameterised enable register with async active-low reset and a reset-value parameter. Instantiate it for pc and ir.
- The remaining registers are in-line always blocks.

Test Plan:
- Reset and first fetch: hold reset=0 for 2 clks, then release. Expect pc=0 and mem_addr=0. Apply mem_rdata=32'h2008_0005, irwrite=1, pcwrite=1, pcsrc=00, alu_result=4. After one posedge: ir=32'h2008_0005, op=6'b001000, pc=4, instr_count=1.
- beq taken vs not taken: ir=0x1000_0003, aluout=0x20, pcwritecond=1, pcsrc=01.
  - alu_zero=1 -> pc=0x20, pc_en=1.
  - alu_zero=0 -> pc unchanged, pc_en=0.
- bne inversion: ir=0x1400_0003, aluout=0x40, pcwritecond=1, pcsrc=01.
  - alu_zero=0 -> pc=0x40.
  - alu_zero=1 -> pc held.
- Jump: pc=0x1000_0008, ir=0x0800_0010, pcwrite=1, pcsrc=10 -> pc=0x1000_0040.
- lw address path: aluout=0x100, iord=1 -> mem_addr=0x100. With mem_rdata=0xDEAD_BEEF, next posedge gives mdr=0xDEAD_BEEF; ir is unchanged since irwrite=0.
- Async reset mid-instruction and error flag:
  - Set pcsrc=11 with pcwrite=1 -> pc held, pcsrc_err=1.
  - Pull reset low between edges -> pc=RESET_PC, instr_count=0 and pcsrc_err=0 before the next posedge.
  - Preload instr_count to all-ones by forced fetches, then one fetch -> instr_count=0.

Source files
------------

// File: rtl/mc_pc_ir_datapath_pkg.sv
// Shared definitions for the multicycle MIPS controller and datapath.
// Holds the next-PC select encodings and the branch opcodes, so the main
// decoder and this datapath always agree on them.
package mc_defs;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC+4 / computed ALU result
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // registered branch target
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // pseudo-direct jump target
    localparam logic [1:0] PCSRC_BAD    = 2'b11;  // illegal; PC holds

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/mc_pc_ir_datapath_en_reg.sv
// mc_en_reg: WIDTH-bit register with load enable and async active-low reset.
//   clk   : clock, loads on posedge when en=1
//   rst_n : async reset, 0 forces q to RST_VAL
//   en    : load enable
//   d     : data in
//   q     : registered data out
module mc_en_reg #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mc_pc_ir_datapath.sv
// mc_pc_ir_datapath: register stage of the multicycle MIPS datapath.
// Holds PC, IR, MDR, A, B and ALUOut, counts fetched instructions and
// flags an illegal next-PC select. Control comes from the main decoder,
// which changes its outputs on negedge; everything here loads on posedge.
//   clk, reset        : clock, async active-low reset
//   pcwrite/pcwritecond/iord/irwrite/pcsrc : decoder controls
//   alu_result/alu_zero/rd1/rd2/mem_rdata  : datapath inputs
//   pc, mem_addr, mem_wdata, ir, op, funct  : PC, memory interface, IR fields
//   mdr, a_reg, b_reg, aluout               : holding registers
//   pc_en, instr_count, pcsrc_err           : PC strobe, fetch count, error
module mc_pc_ir_datapath
    import mc_defs::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int               CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pcwrite,
    input  logic                 pcwritecond,
    input  logic                 iord,
    input  logic                 irwrite,
    input  logic [1:0]           pcsrc,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    input  logic [WIDTH-1:0]     rd1,
    input  logic [WIDTH-1:0]     rd2,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [WIDTH-1:0]     ir,
    output logic [5:0]           op,
    output logic [5:0]           funct,
    output logic [WIDTH-1:0]     mdr,
    output logic [WIDTH-1:0]     a_reg,
    output logic [WIDTH-1:0]     b_reg,
    output logic [WIDTH-1:0]     aluout,
    output logic                 pc_en,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 pcsrc_err
);

    logic             taken;
    logic [WIDTH-1:0] pc_next;

    assign op    = ir[31:26];
    assign funct = ir[5:0];

    // bne inverts the sense of the zero flag; every other conditional
    // branch (beq) takes on zero.
    assign taken = alu_zero ^ (op == OP_BNE);
    assign pc_en = pcwrite | (pcwritecond & taken);

    // Jump target is built from the IR as it stands before the edge, so a
    // same-cycle IR load cannot leak into it.
    always_comb begin
        pc_next = pc;
        case (pcsrc)
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = aluout;
            PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            default:      pc_next = pc;
        endcase
    end

    // Address uses the current PC, so a fetch that also updates PC still
    // reads the instruction at the old PC.
    assign mem_addr  = iord ? aluout : pc;
    assign mem_wdata = b_reg;

    mc_en_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    mc_en_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_ir_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (irwrite),
        .d     (mem_rdata),
        .q     (ir)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdr    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            aluout <= '0;
        end else begin
            mdr    <= mem_rdata;
            a_reg  <= rd1;
            b_reg  <= rd2;
            aluout <= alu_result;
        end
    end

    // Counter wraps silently; it is a statistic, not an architectural value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       instr_count <= '0;
        else if (irwrite) instr_count <= instr_count + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             pcsrc_err <= 1'b0;
        else if (pc_en && (pcsrc == PCSRC_BAD)) pcsrc_err <= 1'b1;
    end

endmodule

// File: tb/tb_mc_pc_ir_datapath.sv
module tb_mc_pc_ir_datapath;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pcwrite, pcwritecond, iord, irwrite, alu_zero;
    logic [1:0]    pcsrc;
    logic [31:0]   alu_result, rd1, rd2, mem_rdata;
    logic [31:0]   pc, mem_addr, mem_wdata, ir, mdr, a_reg, b_reg, aluout;
    logic [5:0]    op, funct;
    logic          pc_en, pcsrc_err;
    logic [CW-1:0] instr_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state, updated from the architectural rules.
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    int unsigned m_cnt;
    bit          m_err;

    mc_pc_ir_datapath #(.WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
        .iord(iord), .irwrite(irwrite), .pcsrc(pcsrc), .alu_result(alu_result),
        .alu_zero(alu_zero), .rd1(rd1), .rd2(rd2), .mem_rdata(mem_rdata),
        .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ir(ir), .op(op),
        .funct(funct), .mdr(mdr), .a_reg(a_reg), .b_reg(b_reg), .aluout(aluout),
        .pc_en(pc_en), .instr_count(instr_count), .pcsrc_err(pcsrc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic bit exp_taken();
        bit is_bne = ((m_ir >> 26) == 32'd5);
        return is_bne ? !alu_zero : alu_zero;
    endfunction

    function automatic bit exp_pc_en();
        return pcwrite || (pcwritecond && exp_taken());
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
        m_cnt = 0; m_err = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_pc"},     pc,          m_pc);
        check({tag, "_ir"},     ir,          m_ir);
        check({tag, "_op"},     op,          m_ir >> 26);
        check({tag, "_funct"},  funct,       m_ir & 32'h3f);
        check({tag, "_mdr"},    mdr,         m_mdr);
        check({tag, "_a"},      a_reg,       m_a);
        check({tag, "_b"},      b_reg,       m_b);
        check({tag, "_wdata"},  mem_wdata,   m_b);
        check({tag, "_aluout"}, aluout,      m_aluout);
        check({tag, "_cnt"},    instr_count, m_cnt % (1 << CW));
        check({tag, "_err"},    pcsrc_err,   m_err);
    endtask

    // Inputs are already applied away from the edge; check combinational
    // outputs, advance one posedge, advance the model, check registers.
    task automatic step(input string tag);
        logic [31:0] npc;
        bit en;
        #1;
        en = exp_pc_en();
        check({tag, "_pc_en"}, pc_en, en);
        check({tag, "_maddr"}, mem_addr, iord ? m_aluout : m_pc);
        case (pcsrc)
            2'd0: npc = alu_result;
            2'd1: npc = m_aluout;
            2'd2: npc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            default: npc = m_pc;
        endcase
        @(posedge clk);
        if (en) m_pc = npc;
        if (en && pcsrc == 2'd3) m_err = 1;
        if (irwrite) begin m_ir = mem_rdata; m_cnt++; end
        m_mdr = mem_rdata; m_a = rd1; m_b = rd2; m_aluout = alu_result;
        #1;
        check_regs(tag);
    endtask

    task automatic idle();
        pcwrite = 0; pcwritecond = 0; iord = 0; irwrite = 0; pcsrc = 0;
        alu_zero = 0; alu_result = 0; rd1 = 0; rd2 = 0; mem_rdata = 0;
    endtask

    task automatic load_ir(input logic [31:0] instr, input logic [31:0] aluv);
        idle(); irwrite = 1; mem_rdata = instr; alu_result = aluv;
        step("ldir");
    endtask

    initial begin
        idle();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("rst");
        check("rst_maddr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1;

        // First fetch: IR and PC update at the same edge.
        idle(); mem_rdata = 32'h2008_0005; irwrite = 1; pcwrite = 1; alu_result = 4;
        step("fetch");
        check("fetch_ir", ir, 32'h2008_0005);
        check("fetch_op", op, 6'b001000);
        check("fetch_pc", pc, 32'h4);
        check("fetch_cnt", instr_count, 1);

        // beq taken / not taken
        load_ir(32'h1000_0003, 32'h20);
        idle(); pcwritecond = 1; pcsrc = 2'b01; alu_zero = 0; alu_result = 32'h20;
        step("beq_nt");
        check("beq_nt_pc", pc, 32'h4);
        idle(); pcwritecond = 1; pcsrc = 2'b01; alu_zero = 1; alu_result = 32'h77;
        step("beq_t");
        check("beq_t_pc", pc, 32'h20);

        // bne inversion
        load_ir(32'h1400_0003, 32'h40);
        idle(); pcwritecond = 1; pcsrc = 2'b01; alu_zero = 1; alu_result = 32'h40;
        step("bne_nt");
        check("bne_nt_pc", pc, 32'h20);
        idle(); pcwritecond = 1; pcsrc = 2'b01; alu_zero = 0;
        step("bne_t");
        check("bne_t_pc", pc, 32'h40);

        // Both enables: pc_en regardless of taken (bne with zero = not taken)
        load_ir(32'h1400_0003, 32'h0);
        idle(); pcwrite = 1; pcwritecond = 1; alu_zero = 1; alu_result = 32'h88;
        step("both");
        check("both_pc", pc, 32'h88);

        // Jump, with a same-edge IR load that must not affect the target.
        idle(); pcwrite = 1; alu_result = 32'h1000_0008; irwrite = 1; mem_rdata = 32'h0800_0010;
        step("jsetup");
        idle(); pcwrite = 1; pcsrc = 2'b10; irwrite = 1; mem_rdata = 32'h0BFF_FFFF;
        step("jump");
        check("jump_pc", pc, 32'h1000_0040);

        // lw address path
        idle(); alu_result = 32'h100;
        step("lwa");
        idle(); iord = 1; mem_rdata = 32'hDEAD_BEEF; alu_result = 32'h100;
        #1 check("lw_maddr", mem_addr, 32'h100);
        step("lw");
        check("lw_mdr", mdr, 32'hDEAD_BEEF);
        check("lw_ir", ir, 32'h0BFF_FFFF);

        // pcsrc=11 holds PC and sets the sticky flag
        idle(); pcwrite = 1; pcsrc = 2'b11; alu_result = 32'h1234;
        step("bad");
        check("bad_err", pcsrc_err, 1);
        idle();
        step("bad_sticky");
        check("bad_sticky_err", pcsrc_err, 1);

        // Async reset between edges
        #3 reset = 0;
        #1;
        model_reset();
        check("arst_pc", pc, 32'h0);
        check("arst_cnt", instr_count, 0);
        check("arst_err", pcsrc_err, 0);
        check_regs("arst");
        @(negedge clk);
        reset = 1;

        // Counter wrap
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            idle(); irwrite = 1; mem_rdata = $urandom; pcwrite = 1; alu_result = $urandom;
            step("cfill");
        end
        check("cnt_full", instr_count, (1 << CW) - 1);
        idle(); irwrite = 1; mem_rdata = $urandom;
        step("cwrap");
        check("cnt_wrap", instr_count, 0);

        // Random controls against the model
        for (int i = 0; i < 400; i++) begin
            pcwrite     = ($urandom_range(0, 3) == 0);
            pcwritecond = $urandom_range(0, 1);
            iord        = $urandom_range(0, 1);
            irwrite     = $urandom_range(0, 1);
            pcsrc       = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            alu_zero    = $urandom_range(0, 1);
            alu_result  = $urandom;
            rd1         = $urandom;
            rd2         = $urandom;
            mem_rdata   = $urandom;
            // Bias IR toward branch opcodes so the condition path is exercised.
            if (irwrite && $urandom_range(0, 1))
                mem_rdata[31:26] = $urandom_range(0, 1) ? 6'b000100 : 6'b000101;
            step("rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
